// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: start / data (LSB first) / optional parity / 1-2 stop.
// Rejects short start glitches and reports parity and framing errors with each delivered word.
module uart_rx_param #(
    parameter int CLK_DIV     = 10,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic                 rx_vld,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int   HALF   = CLK_DIV / 2;
    localparam int   NBITS  = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int   CNT_W  = $clog2(CLK_DIV);
    localparam int   IDX_W  = $clog2(NBITS);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_bad;
    logic                   r_stop_bad;
    logic                   r_vld;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_perr;
    logic                   r_ferr;

    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic                   w_par_bad_nxt;
    logic                   w_stop_bad_nxt;
    logic                   w_deliver;
    logic                   w_rx;
    logic                   w_fall;
    logic                   w_sample;

    // Synchroniser output is the oldest stage; the edge is seen one stage earlier.
    assign w_rx     = r_sync[SYNC_STAGES-1];
    assign w_fall   = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-2];
    assign w_sample = (r_cnt == CNT_W'(HALF - 1));

    // NOTE: synchroniser resets to the idle-high level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = (r_cnt == CNT_W'(CLK_DIV - 1)) ? '0 : r_cnt + CNT_W'(1);
        w_idx_nxt      = r_idx;
        w_shift_nxt    = r_shift;
        w_par_bad_nxt  = r_par_bad;
        w_stop_bad_nxt = r_stop_bad;
        w_deliver      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (w_fall) begin
                    w_state_nxt    = S_START;
                    w_par_bad_nxt  = 1'b0;
                    w_stop_bad_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_sample) begin
                    if (w_rx) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(DATA_BITS)) begin
                        w_state_nxt = PAR_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_sample) begin
                    w_par_bad_nxt = ((^r_shift) ^ PAR_ODD) != w_rx;
                    w_idx_nxt     = r_idx + IDX_W'(1);
                    w_state_nxt   = S_STOP;
                end
            end
            S_STOP: begin
                if (w_sample) begin
                    w_stop_bad_nxt = r_stop_bad | ~w_rx;
                    // Leave half a bit early so the next start edge is never missed.
                    if (r_idx == IDX_W'(NBITS - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_deliver   = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_par_bad  <= w_par_bad_nxt;
            r_stop_bad <= w_stop_bad_nxt;
        end
    end

    // Word and both error flags update together with the strobe and hold until the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_vld <= w_deliver;
            if (w_deliver) begin
                r_data <= r_shift;
                r_perr <= PAR_EN & w_par_bad_nxt;
                r_ferr <= w_stop_bad_nxt;
            end
        end
    end

    assign rx_vld     = r_vld;
    assign rx_data    = r_data;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 8E1 and 7N2 instances on separate lines.
// Delivered words are captured at the falling clock edge and compared with hand-computed values.
module tb_uart_rx_param;

    localparam int CLK_DIV = 10;

    logic       clk;
    logic       rst_n;
    logic [2:0] line;

    logic       vld0, perr0, ferr0, busy0;
    logic [7:0] data0;
    logic       vld1, perr1, ferr1, busy1;
    logic [7:0] data1;
    logic       vld2, perr2, ferr2, busy2;
    logic [6:0] data2;

    uart_rx_param #(.CLK_DIV(CLK_DIV)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line[0]),
        .rx_vld(vld0), .rx_data(data0), .parity_err(perr0),
        .frame_err(ferr0), .busy(busy0)
    );

    uart_rx_param #(.CLK_DIV(CLK_DIV), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line[1]),
        .rx_vld(vld1), .rx_data(data1), .parity_err(perr1),
        .frame_err(ferr1), .busy(busy1)
    );

    uart_rx_param #(.CLK_DIV(CLK_DIV), .DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line[2]),
        .rx_vld(vld2), .rx_data(data2), .parity_err(perr2),
        .frame_err(ferr2), .busy(busy2)
    );

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } cap_t;

    cap_t cap_q[$];
    int   cycle;
    int   t_start;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (vld0) cap_q.push_back('{0, 9'(data0), perr0, ferr0, cycle});
        if (vld1) cap_q.push_back('{1, 9'(data1), perr1, ferr1, cycle});
        if (vld2) cap_q.push_back('{2, 9'(data2), perr2, ferr2, cycle});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input int sel, input logic b);
        line[sel] = b;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data, input int dbits,
                              input int par_en, input logic par_bit,
                              input int nstop, input logic stop_val);
        t_start = cycle;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < dbits; i++) drive_bit(sel, data[i]);
        if (par_en != 0) drive_bit(sel, par_bit);
        repeat (nstop) drive_bit(sel, stop_val);
    endtask

    task automatic pop_check(input string tag, input int sel, input logic [8:0] data,
                             input logic perr, input logic ferr);
        cap_t c;
        if (cap_q.size() == 0) return;
        c = cap_q.pop_front();
        check({tag, "_sel"},  c.sel,  sel);
        check({tag, "_data"}, c.data, data);
        check({tag, "_perr"}, c.perr, perr);
        check({tag, "_ferr"}, c.ferr, ferr);
    endtask

    initial begin
        cap_t c;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        line     = 3'b111;

        repeat (3) @(negedge clk);
        check("rst_vld",   vld0,  1'b0);
        check("rst_data",  data0, 8'h00);
        check("rst_perr",  perr0, 1'b0);
        check("rst_ferr",  ferr0, 1'b0);
        check("rst_busy",  {busy0, busy1, busy2}, 3'b000);
        rst_n = 1'b1;
        repeat (2) drive_bit(0, 1'b1);

        // 8N1 0xA5: first sync'd edge lands 2 posedges after the line drop (T0), pulse captured at T0+96.
        cap_q.delete();
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
        repeat (2) drive_bit(0, 1'b1);
        check("a5_count", cap_q.size(), 1);
        if (cap_q.size() > 0) check("a5_latency", cap_q[0].cyc - t_start, 98);
        pop_check("a5", 0, 9'h0A5, 1'b0, 1'b0);
        check("a5_busy_idle", busy0, 1'b0);
        check("a5_data_held", data0, 8'hA5);

        // 3-clock low glitch: START entered at T0 (n=3), rejected at T0+5 (n=8).
        cap_q.delete();
        line[0] = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 3) line[0] = 1'b1;
            if (n == 2) check("glitch_busy_n2", busy0, 1'b0);
            if (n == 3) check("glitch_busy_n3", busy0, 1'b1);
            if (n == 7) check("glitch_busy_n7", busy0, 1'b1);
            if (n == 8) check("glitch_busy_n8", busy0, 1'b0);
        end
        repeat (3) drive_bit(0, 1'b1);
        check("glitch_no_vld", cap_q.size(), 0);
        check("glitch_data_kept", data0, 8'hA5);

        // Even parity: 0x3C has four ones, so the correct parity bit is 0.
        cap_q.delete();
        repeat (2) drive_bit(1, 1'b1);
        send_frame(1, 9'h03C, 8, 1, 1'b1, 1, 1'b1);
        repeat (2) drive_bit(1, 1'b1);
        check("par_bad_count", cap_q.size(), 1);
        pop_check("par_bad", 1, 9'h03C, 1'b1, 1'b0);
        check("par_bad_held", perr1, 1'b1);
        send_frame(1, 9'h03C, 8, 1, 1'b0, 1, 1'b1);
        repeat (2) drive_bit(1, 1'b1);
        pop_check("par_ok", 1, 9'h03C, 1'b0, 1'b0);
        send_frame(1, 9'h007, 8, 1, 1'b1, 1, 1'b1);
        repeat (2) drive_bit(1, 1'b1);
        pop_check("par_odd_cnt", 1, 9'h007, 1'b0, 1'b0);
        check("par_tail_count", cap_q.size(), 0);

        // Stop bit 0 followed by a 40-bit break: one errored word, then silence.
        cap_q.delete();
        send_frame(0, 9'h012, 8, 0, 1'b0, 1, 1'b0);
        repeat (40) drive_bit(0, 1'b0);
        check("brk_count", cap_q.size(), 1);
        pop_check("brk", 0, 9'h012, 1'b0, 1'b1);
        check("brk_ferr_held", ferr0, 1'b1);
        check("brk_busy", busy0, 1'b0);
        repeat (2) drive_bit(0, 1'b1);
        send_frame(0, 9'h000, 8, 0, 1'b0, 1, 1'b1);
        repeat (2) drive_bit(0, 1'b1);
        check("after_brk_count", cap_q.size(), 1);
        pop_check("after_brk", 0, 9'h000, 1'b0, 1'b0);
        check("after_brk_ferr", ferr0, 1'b0);

        // Back-to-back frames with no idle gap, 8N1 then 7N2.
        cap_q.delete();
        send_frame(0, 9'h055, 8, 0, 1'b0, 1, 1'b1);
        send_frame(0, 9'h0AA, 8, 0, 1'b0, 1, 1'b1);
        repeat (2) drive_bit(0, 1'b1);
        check("b2b_8n1_count", cap_q.size(), 2);
        pop_check("b2b_55", 0, 9'h055, 1'b0, 1'b0);
        pop_check("b2b_aa", 0, 9'h0AA, 1'b0, 1'b0);
        send_frame(2, 9'h05A, 7, 0, 1'b0, 2, 1'b1);
        send_frame(2, 9'h027, 7, 0, 1'b0, 2, 1'b1);
        repeat (2) drive_bit(2, 1'b1);
        check("b2b_7n2_count", cap_q.size(), 2);
        pop_check("b2b_5a", 2, 9'h05A, 1'b0, 1'b0);
        pop_check("b2b_27", 2, 9'h027, 1'b0, 1'b0);

        // Reset in the middle of the data bits of 0x81 aborts the frame silently.
        cap_q.delete();
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        repeat (5) @(negedge clk);
        check("mid_busy_before", busy0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_data", data0, 8'h00);
        line[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) drive_bit(0, 1'b1);
        check("mid_no_stale", cap_q.size(), 0);
        send_frame(0, 9'h081, 8, 0, 1'b0, 1, 1'b1);
        repeat (2) drive_bit(0, 1'b1);
        check("post_rst_count", cap_q.size(), 1);
        pop_check("post_rst", 0, 9'h081, 1'b0, 1'b0);
        check("post_rst_data", data0, 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
